stream_checker: RTL and testbench
=================================

// Module: stream_checker
// PURPOSE
//  Receive-side endpoint for the sequential-counter traffic on a t_DATA_STREAM link.
//  Accepts beats from the simulated-ethernet fabric and checks that data values are consecutive
//  64-bit integers. Checks that each packet is PKT_BEATS beats, with sop on the first beat and eop
//  on the last. Keeps beat, packet and error statistics for the demo/bench to read.
// PARAMETERS
//  PKT_BEATS  4   beats per packet; sop is expected on beat 0 and eop on beat PKT_BEATS-1 (>=2)
//  BP_PERIOD  0   backpressure: 0 = rx.ready held high; N>=2 = ready low 1 cycle in every N
//  CNT_W      32  width of all statistics counters
// PORTS
//  clk              in   1      system clock
//  resetn           in   1      asynchronous active-low reset
//  rx               rx   intf   t_DATA_STREAM.rx: data[63:0], valid, sop, eop, addr in; ready out
//  clear_stats      in   1      1-cycle pulse: zero all counters, err_flag and locked
//  locked           out  1      first beat has been accepted; expected value is valid
//  err_flag         out  1      sticky: any data or framing error since reset/clear
//  beat_count       out  CNT_W  accepted beats (valid & ready)
//  pkt_count        out  CNT_W  accepted beats carrying eop
//  data_err_count   out  CNT_W  beats whose data != expected
//  frame_err_count  out  CNT_W  beats whose sop/eop disagree with the beat position
// BEHAVIOUR
//  - Reset (resetn=0, async): all counters 0, locked=0, err_flag=0, expected=0, beat_idx=0,
//    bp_cnt=0, rx.ready=0.
//  - Reset is deasserted synchronously by the system. A mid-packet reset discards all state.
//  - Accept: a beat is accepted when rx.valid & rx.ready are high at a clk edge; nothing else counts.
//  - rx.ready is registered:
//    - BP_PERIOD=0: ready=1 from the first cycle after reset release.
//    - BP_PERIOD=N: bp_cnt counts 0..N-1 and wraps; ready=0 when bp_cnt==N-1, else 1.
//  - Data check (all counter updates apply in the cycle after the accept):
//    - If !locked: the beat seeds expected=data+1 and sets locked=1. No data error is counted.
//    - If locked and data!=expected: data_err_count+1, err_flag=1, expected=data+1 (resync).
//    - Otherwise expected=expected+1. 64-bit wrap: data 2^64-1 followed by 0 is legal.
//  - Framing, using beat_idx (0..PKT_BEATS-1):
//    - An error is flagged if sop!=(beat_idx==0) or eop!=(beat_idx==PKT_BEATS-1).
//    - At most one frame error per beat: frame_err_count+1, err_flag=1.
//    - Next beat_idx: 1 if sop (resync on sop); 0 if eop; else beat_idx+1.
//    - Next beat_idx wraps at PKT_BEATS-1 to 0 when eop is missing.
//  - FSM, 2 states:
//    - HUNT: before lock. Any accepted beat moves to TRACK.
//    - TRACK: checks are active.
//    - In HUNT, frame checks are suppressed until the first sop. Accepted beats still count.
//  - Counters saturate at 2^CNT_W-1.
//  - pkt_count increments on an accepted eop regardless of errors.
//  - clear_stats has priority over a same-cycle accept: counters/err_flag/locked clear and that
//    beat's stats are dropped. The beat is still accepted (ready is unaffected).
//    - The FSM returns to HUNT and beat_idx=0.
//  - rx.addr is ignored. No combinational path from rx inputs to rx.ready.
// TESTING
//  1. Reset, then beats data 0..15 with sop on data[1:0]==0 and eop on ==3, BP_PERIOD=0
//     -> beat_count=16, pkt_count=4, both error counts 0, err_flag=0, locked=1.
//  2. Stream 0..7, then 9..15 (value 8 dropped)
//     -> data_err_count=1, err_flag=1, no further data errors after the resync.
//  3. Same stream as 1 but beat 6 has eop=1 (misplaced)
//     -> frame_err_count>=1. Counting resumes correctly at the next sop (data 8).
//  4. First beat seen is data 0xFFFF_FFFF_FFFF_FFFE with sop, followed by ...FFFF, 0, 1 (eop)
//     -> no data error (wrap is legal), locked=1, pkt_count=1.
//  5. BP_PERIOD=4 with valid held high -> ready low exactly 1 of every 4 cycles. After 40 cycles
//     beat_count=30 and data_err_count=0.
//  6. Assert resetn=0 after 2 beats, mid-packet
//     -> all outputs zero immediately (async), ready=0.
//     After release, a stream starting at data 100 (sop) locks with no errors.

Source files
------------

// File: rtl/stream_checker.sv
// rtl/stream_checker.sv - receive-side checker for sequential-counter packet traffic
module stream_checker #(
  parameter int PKT_BEATS = 4,
  parameter int BP_PERIOD = 0,
  parameter int CNT_W     = 32,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [63:0]       rx_data,
  input  logic              rx_valid,
  input  logic              rx_sop,
  input  logic              rx_eop,
  input  logic [ADDR_W-1:0] rx_addr,
  output logic              rx_ready,
  input  logic              clear_stats,
  output logic              locked,
  output logic              err_flag,
  output logic [CNT_W-1:0]  beat_count,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  data_err_count,
  output logic [CNT_W-1:0]  frame_err_count
);

  localparam int IDX_W = $clog2(PKT_BEATS);
  localparam int BP_W  = (BP_PERIOD >= 2) ? $clog2(BP_PERIOD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BEATS - 1);
  localparam logic [BP_W-1:0]  BP_LAST  = BP_W'(BP_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [63:0]       expected_q, expected_d;
  logic [IDX_W-1:0]  beat_idx_q, beat_idx_d;
  logic              framed_q, framed_d;
  logic              err_flag_q, err_flag_d;
  logic [CNT_W-1:0]  beat_count_q, beat_count_d;
  logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;
  logic [CNT_W-1:0]  data_err_q, data_err_d;
  logic [CNT_W-1:0]  frame_err_q, frame_err_d;
  logic [BP_W-1:0]   bp_cnt_q, bp_cnt_d;
  logic              ready_q, ready_d;

  logic accept;
  logic data_err;
  logic frame_err;
  logic unused_addr;

  // Address is carried by the link but has no meaning for this endpoint.
  assign unused_addr = ^rx_addr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign accept = rx_valid & ready_q;

  // The first beat after reset/clear only seeds the expected value.
  assign data_err = (state_q == TRACK) && (rx_data != expected_q);

  // Framing is only judged once a sop has been seen since reset/clear (or on the sop beat itself).
  assign frame_err = (framed_q | rx_sop) &&
                     ((rx_sop != (beat_idx_q == '0)) || (rx_eop != (beat_idx_q == LAST_IDX)));

  // Backpressure pattern: ready depends only on the free-running phase counter, never on rx inputs.
  always_comb begin
    bp_cnt_d = '0;
    ready_d  = 1'b1;
    if (BP_PERIOD >= 2) begin
      bp_cnt_d = (bp_cnt_q == BP_LAST) ? '0 : bp_cnt_q + BP_W'(1);
      ready_d  = (bp_cnt_d != BP_LAST);
    end
  end

  // Lock FSM, data/framing checks and saturating statistics; clear wins over a same-cycle accept.
  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    beat_idx_d   = beat_idx_q;
    framed_d     = framed_q;
    err_flag_d   = err_flag_q;
    beat_count_d = beat_count_q;
    pkt_count_d  = pkt_count_q;
    data_err_d   = data_err_q;
    frame_err_d  = frame_err_q;
    if (clear_stats) begin
      state_d      = HUNT;
      expected_d   = '0;
      beat_idx_d   = '0;
      framed_d     = 1'b0;
      err_flag_d   = 1'b0;
      beat_count_d = '0;
      pkt_count_d  = '0;
      data_err_d   = '0;
      frame_err_d  = '0;
    end else if (accept) begin
      state_d      = TRACK;
      // Seed, resync and in-order cases all leave data+1 as the next expected value.
      expected_d   = rx_data + 64'd1;
      framed_d     = framed_q | rx_sop;
      if (rx_sop) begin
        beat_idx_d = IDX_W'(1);
      end else if (rx_eop || (beat_idx_q == LAST_IDX)) begin
        beat_idx_d = '0;
      end else begin
        beat_idx_d = beat_idx_q + IDX_W'(1);
      end
      beat_count_d = sat_inc(beat_count_q);
      if (rx_eop) begin
        pkt_count_d = sat_inc(pkt_count_q);
      end
      if (data_err) begin
        data_err_d = sat_inc(data_err_q);
      end
      if (frame_err) begin
        frame_err_d = sat_inc(frame_err_q);
      end
      if (data_err || frame_err) begin
        err_flag_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= HUNT;
      expected_q   <= '0;
      beat_idx_q   <= '0;
      framed_q     <= 1'b0;
      err_flag_q   <= 1'b0;
      beat_count_q <= '0;
      pkt_count_q  <= '0;
      data_err_q   <= '0;
      frame_err_q  <= '0;
      bp_cnt_q     <= '0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      beat_idx_q   <= beat_idx_d;
      framed_q     <= framed_d;
      err_flag_q   <= err_flag_d;
      beat_count_q <= beat_count_d;
      pkt_count_q  <= pkt_count_d;
      data_err_q   <= data_err_d;
      frame_err_q  <= frame_err_d;
      bp_cnt_q     <= bp_cnt_d;
      ready_q      <= ready_d;
    end
  end

  assign rx_ready        = ready_q;
  assign locked          = (state_q == TRACK);
  assign err_flag        = err_flag_q;
  assign beat_count      = beat_count_q;
  assign pkt_count       = pkt_count_q;
  assign data_err_count  = data_err_q;
  assign frame_err_count = frame_err_q;

endmodule

// File: tb/tb_stream_checker.sv
// tb/tb_stream_checker.sv - scoreboard bench for stream_checker
module tb_stream_checker;

  localparam int PKT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        sel;
  logic        vld, clr, sop, eop;
  logic [63:0] dat;
  logic [15:0] addr;

  logic vld0, vld4, clr0, clr4;
  assign vld0 = vld & ~sel;
  assign vld4 = vld & sel;
  assign clr0 = clr & ~sel;
  assign clr4 = clr & sel;

  logic        rdy0, lock0, err0;
  logic [31:0] bc0, pc0, dc0, fc0;
  logic        rdy4, lock4, err4;
  logic [4:0]  bc4, pc4, dc4, fc4;

  stream_checker #(.PKT_BEATS(PKT), .BP_PERIOD(0), .CNT_W(32), .ADDR_W(16)) dut0 (
    .clk(clk), .resetn(resetn), .rx_data(dat), .rx_valid(vld0), .rx_sop(sop), .rx_eop(eop),
    .rx_addr(addr), .rx_ready(rdy0), .clear_stats(clr0), .locked(lock0), .err_flag(err0),
    .beat_count(bc0), .pkt_count(pc0), .data_err_count(dc0), .frame_err_count(fc0));

  stream_checker #(.PKT_BEATS(PKT), .BP_PERIOD(4), .CNT_W(5), .ADDR_W(16)) dut4 (
    .clk(clk), .resetn(resetn), .rx_data(dat), .rx_valid(vld4), .rx_sop(sop), .rx_eop(eop),
    .rx_addr(addr), .rx_ready(rdy4), .clear_stats(clr4), .locked(lock4), .err_flag(err4),
    .beat_count(bc4), .pkt_count(pc4), .data_err_count(dc4), .frame_err_count(fc4));

  logic        m_rdy, m_lock, m_err;
  logic [31:0] m_bc, m_pc, m_dc, m_fc;
  assign m_rdy  = sel ? rdy4 : rdy0;
  assign m_lock = sel ? lock4 : lock0;
  assign m_err  = sel ? err4 : err0;
  assign m_bc   = sel ? {27'd0, bc4} : bc0;
  assign m_pc   = sel ? {27'd0, pc4} : pc0;
  assign m_dc   = sel ? {27'd0, dc4} : dc0;
  assign m_fc   = sel ? {27'd0, fc4} : fc0;

  typedef struct {
    int unsigned beats;
    int unsigned pkts;
    int unsigned derr;
    int unsigned ferr;
    bit          err;
    bit          lock;
  } snap_t;

  snap_t exp_q[$];

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  // Reference model state: statistics plus the packet-position view of framing.
  int unsigned mb, mp, md, mf;
  bit          me, ml, mframed;
  logic [63:0] mexp;
  int          mpos;

  task automatic chk(input string name, input longint unsigned got, input longint unsigned want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic int unsigned cmax();
    return sel ? 32'd31 : 32'hFFFF_FFFF;
  endfunction

  function automatic int unsigned bump(input int unsigned v);
    return (v >= cmax()) ? v : v + 1;
  endfunction

  task automatic model_clear();
    mb = 0; mp = 0; md = 0; mf = 0;
    me = 0; ml = 0; mframed = 0; mpos = 0;
  endtask

  task automatic model_reset();
    model_clear();
    mexp = '0;
    exp_q.delete();
  endtask

  task automatic push_snap();
    snap_t sn;
    sn.beats = mb; sn.pkts = mp; sn.derr = md; sn.ferr = mf; sn.err = me; sn.lock = ml;
    exp_q.push_back(sn);
  endtask

  task automatic model_beat(input logic [63:0] d, input bit s, input bit e);
    bit de, fe;
    de = ml && (d != mexp);
    fe = (mframed || s) && ((s != (mpos == 0)) || (e != (mpos == PKT - 1)));
    mexp = d + 64'd1;
    ml = 1;
    mframed = mframed | s;
    if (s)      mpos = 1;
    else if (e) mpos = 0;
    else        mpos = (mpos + 1) % PKT;
    mb = bump(mb);
    if (e)  mp = bump(mp);
    if (de) md = bump(md);
    if (fe) mf = bump(mf);
    if (de || fe) me = 1;
    push_snap();
  endtask

  // Monitor: every accepted beat must show the statistics the model predicted for it.
  logic acc_q;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) acc_q <= 1'b0;
    else         acc_q <= vld & m_rdy;
  end

  always @(negedge clk) begin
    if (acc_q) begin
      snap_t sn;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got accept expected none at %0t", $time);
      end else begin
        sn = exp_q.pop_front();
        chk("sb_beat_count", m_bc, sn.beats);
        chk("sb_pkt_count", m_pc, sn.pkts);
        chk("sb_data_err_count", m_dc, sn.derr);
        chk("sb_frame_err_count", m_fc, sn.ferr);
        chk("sb_err_flag", m_err, sn.err);
        chk("sb_locked", m_lock, sn.lock);
      end
    end
  end

  // Drive one beat from a negedge until accepted; clr may ride along on the first cycle.
  task automatic send(input logic [63:0] d, input bit s, input bit e, input bit c);
    int g;
    bit done;
    g = 0;
    done = 0;
    dat = d; sop = s; eop = e; clr = c; vld = 1'b1;
    addr = 16'($urandom);
    while (!done) begin
      if (clr) model_clear();
      if (m_rdy) begin
        if (clr) push_snap();
        else     model_beat(d, s, e);
        done = 1;
      end else begin
        clr = 1'b0;
        g++;
        if (g > 20) begin
          n_chk++;
          n_fail++;
          $display("FAIL ready_timeout: got ready=0 for %0d cycles expected 1", g);
          done = 1;
        end
        @(negedge clk);
      end
    end
    @(negedge clk);
    vld = 1'b0;
    clr = 1'b0;
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    vld = 1'b0;
    clr = 1'b1;
    model_clear();
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("clear_beat_count", m_bc, 0);
    chk("clear_locked", m_lock, 0);
    chk("clear_err_flag", m_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d;
    int p, j, lows, accs;
    bit s, e, c;

    sel = 0; vld = 0; clr = 0; dat = '0; sop = 0; eop = 0; addr = '0; resetn = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_ready0", rdy0, 0);
    chk("reset_ready4", rdy4, 0);
    chk("reset_locked", lock0, 0);
    chk("reset_err_flag", err0, 0);
    chk("reset_beat_count", bc0, 0);
    chk("reset_pkt_count", pc0, 0);
    chk("reset_data_err", dc0, 0);
    chk("reset_frame_err", fc0, 0);
    resetn = 1;
    @(negedge clk);
    chk("ready_after_release", rdy0, 1);

    // Clean stream 0..15, framing from data[1:0].
    for (int k = 0; k < 16; k++) send(64'(k), (k % 4) == 0, (k % 4) == 3, 0);
    idle(2);
    chk("t1_beat_count", m_bc, 16);
    chk("t1_pkt_count", m_pc, 4);
    chk("t1_data_err", m_dc, 0);
    chk("t1_frame_err", m_fc, 0);
    chk("t1_err_flag", m_err, 0);
    chk("t1_locked", m_lock, 1);

    // Dropped value 8: single data error, resync afterwards.
    do_clear();
    j = 0;
    for (int k = 0; k < 16; k++) begin
      if (k != 8) begin
        send(64'(k), (j % 4) == 0, (j % 4) == 3, 0);
        j++;
      end
    end
    idle(2);
    chk("t2_data_err", m_dc, 1);
    chk("t2_err_flag", m_err, 1);
    chk("t2_frame_err", m_fc, 0);

    // Misplaced eop on beat 6.
    do_clear();
    for (int k = 0; k < 16; k++) send(64'(k), (k % 4) == 0, ((k % 4) == 3) || (k == 6), 0);
    idle(2);
    chk("t3_frame_err_seen", (m_fc >= 1) ? 1 : 0, 1);
    chk("t3_data_err", m_dc, 0);
    chk("t3_pkt_count", m_pc, 5);

    // 64-bit wrap across a packet is legal.
    do_clear();
    send(64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0);
    send(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
    send(64'h0, 0, 0, 0);
    send(64'h1, 0, 1, 0);
    idle(2);
    chk("t4_data_err", m_dc, 0);
    chk("t4_locked", m_lock, 1);
    chk("t4_pkt_count", m_pc, 1);
    chk("t4_frame_err", m_fc, 0);

    // Clear together with an accept drops that beat's statistics.
    send(64'd50, 1, 0, 1);
    idle(1);
    chk("clr_accept_beat_count", m_bc, 0);
    chk("clr_accept_locked", m_lock, 0);

    // Randomized traffic: data jumps, framing flips, gaps and occasional clears.
    do_clear();
    d = {$urandom, $urandom};
    p = 0;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 99) < 5) d = {$urandom, $urandom};
      s = (p == 0);
      e = (p == PKT - 1);
      if ($urandom_range(0, 19) == 0) s = ~s;
      if ($urandom_range(0, 19) == 0) e = ~e;
      c = ($urandom_range(0, 49) == 0);
      send(d, s, e, c);
      d = d + 64'd1;
      p = (p + 1) % PKT;
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    // Backpressure 1-in-4 with valid held high for 40 cycles, then saturation of 5-bit counters.
    sel = 1;
    model_reset();
    idle(2);
    lows = 0;
    accs = 0;
    d = 64'd0;
    p = 0;
    for (int i = 0; i < 40; i++) begin
      dat = d; sop = (p == 0); eop = (p == PKT - 1); clr = 0; vld = 1;
      if (m_rdy) begin
        model_beat(d, p == 0, p == PKT - 1);
        d = d + 64'd1;
        p = (p + 1) % PKT;
        accs++;
      end else begin
        lows++;
      end
      @(negedge clk);
    end
    vld = 0;
    idle(2);
    chk("t5_ready_low_cycles", lows, 10);
    chk("t5_accepts", accs, 30);
    chk("t5_beat_count", bc4, 30);
    chk("t5_data_err", dc4, 0);
    for (int k = 0; k < 10; k++) begin
      send(d, p == 0, p == PKT - 1, 0);
      d = d + 64'd1;
      p = (p + 1) % PKT;
    end
    idle(2);
    chk("sat_beat_count", bc4, 31);
    chk("sat_data_err", dc4, 0);

    // Asynchronous reset in the middle of a packet.
    sel = 0;
    do_clear();
    send(64'd200, 1, 0, 0);
    send(64'd201, 0, 0, 0);
    idle(2);
    @(posedge clk);
    #2;
    resetn = 0;
    #1;
    chk("t6_ready0", rdy0, 0);
    chk("t6_ready4", rdy4, 0);
    chk("t6_locked", lock0, 0);
    chk("t6_err_flag", err0, 0);
    chk("t6_beat_count", bc0, 0);
    chk("t6_pkt_count", pc0, 0);
    chk("t6_data_err", dc0, 0);
    chk("t6_frame_err", fc0, 0);
    chk("t6_beat_count4", bc4, 0);
    model_reset();
    @(negedge clk);
    resetn = 1;
    for (int k = 0; k < 8; k++) send(64'(100 + k), (k % 4) == 0, (k % 4) == 3, 0);
    idle(2);
    chk("t6_relock", m_lock, 1);
    chk("t6_post_beat_count", m_bc, 8);
    chk("t6_post_data_err", m_dc, 0);
    chk("t6_post_frame_err", m_fc, 0);
    chk("t6_post_err_flag", m_err, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
